// File: rtl/prop_checker_pkg.sv
// Shared types for the property checker: rule encoding and implication lane states.
package prop_checker_pkg;

  typedef enum logic [1:0] {
    CHK_EQUAL = 2'd0,
    CHK_MUTEX = 2'd1,
    CHK_IMPLY = 2'd2,
    CHK_OFF   = 2'd3
  } chk_mode_e;

  typedef enum logic {
    LS_IDLE = 1'b0,
    LS_WAIT = 1'b1
  } lane_state_e;

endpackage

// File: rtl/prop_chk_lane.sv
// One monitored channel: rule evaluation, implication FSM, registered pulses,
// sticky fail flag and saturating fail counter.
module prop_chk_lane
  import prop_checker_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int WIN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic [WIN_W-1:0] win,
  output logic             pass_p,
  output logic             fail_p,
  output logic             fail_ev,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] fail_cnt
);

  lane_state_e      state_reg, state_next;
  logic [WIN_W-1:0] wcnt_reg, wcnt_next;
  logic [1:0]       prev_mode_reg;
  logic             pass_reg, fail_reg, pass_next, fail_next;
  logic             sticky_reg;
  logic [CNT_W-1:0] cnt_reg;

  chk_mode_e        mode_e;
  logic             mode_chg;
  logic [WIN_W-1:0] bound;
  logic             timeout;

  assign mode_e   = chk_mode_e'(mode);
  assign mode_chg = (mode != prev_mode_reg);
  assign bound    = (win == '0) ? WIN_W'(1) : win;
  // >= rather than == so a window shrunk mid-flight still times out
  assign timeout  = (wcnt_reg >= bound);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LS_IDLE;
      wcnt_reg      <= '0;
      prev_mode_reg <= mode;
      pass_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      sticky_reg    <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      wcnt_reg      <= wcnt_next;
      prev_mode_reg <= mode;
      pass_reg      <= pass_next;
      fail_reg      <= fail_next;
      if (clr) begin
        sticky_reg <= 1'b0;
        cnt_reg    <= '0;
      end else if (fail_next) begin
        sticky_reg <= 1'b1;
        if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    if (mode_chg || mode_e != CHK_IMPLY) begin
      state_next = LS_IDLE;
      wcnt_next  = '0;
    end else if (en) begin
      case (state_reg)
        LS_IDLE: begin
          if (a) begin
            state_next = LS_WAIT;
            wcnt_next  = WIN_W'(1);
          end
        end
        LS_WAIT: begin
          if (b || timeout) begin
            state_next = LS_IDLE;
            wcnt_next  = '0;
          end else begin
            wcnt_next = wcnt_reg + WIN_W'(1);
          end
        end
        default: begin
          state_next = LS_IDLE;
          wcnt_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pass_next = 1'b0;
    fail_next = 1'b0;
    if (en && !mode_chg) begin
      case (mode_e)
        CHK_EQUAL: begin
          pass_next = (a == b);
          fail_next = (a != b);
        end
        CHK_MUTEX: begin
          pass_next = !(a && b);
          fail_next = a && b;
        end
        CHK_IMPLY: begin
          if (state_reg == LS_WAIT) begin
            pass_next = b;
            fail_next = !b && timeout;
          end
        end
        default: ;
      endcase
    end
  end

  assign pass_p      = pass_reg;
  assign fail_p      = fail_reg;
  assign fail_ev     = fail_next;
  assign fail_sticky = sticky_reg;
  assign fail_cnt    = cnt_reg;

endmodule

// File: rtl/prop_checker.sv
// Multi-channel property checker: NUM_CH rule lanes plus first-failure capture.
module prop_checker
  import prop_checker_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 3,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [WIN_W-1:0]        win,
  output logic [NUM_CH-1:0]       pass_p,
  output logic [NUM_CH-1:0]       fail_p,
  output logic [NUM_CH-1:0]       fail_sticky,
  output logic [CNT_W*NUM_CH-1:0] fail_cnt,
  output logic                    first_vld,
  output logic [CH_W-1:0]         first_ch
);

  logic [NUM_CH-1:0] fail_ev;
  logic [CH_W-1:0]   low_idx;
  logic              first_vld_reg;
  logic [CH_W-1:0]   first_ch_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    prop_chk_lane #(
      .CNT_W(CNT_W),
      .WIN_W(WIN_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .a          (a[gi]),
      .b          (b[gi]),
      .mode       (mode[2*gi +: 2]),
      .win        (win),
      .pass_p     (pass_p[gi]),
      .fail_p     (fail_p[gi]),
      .fail_ev    (fail_ev[gi]),
      .fail_sticky(fail_sticky[gi]),
      .fail_cnt   (fail_cnt[gi*CNT_W +: CNT_W])
    );
  end

  // Descending scan so the lowest failing index wins
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_ev[i]) low_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      first_vld_reg <= 1'b0;
      first_ch_reg  <= '0;
    end else if (!first_vld_reg && (|fail_ev)) begin
      first_vld_reg <= 1'b1;
      first_ch_reg  <= low_idx;
    end
  end

  assign first_vld = first_vld_reg;
  assign first_ch  = first_ch_reg;

endmodule

// File: tb/tb_prop_checker.sv
// Directed self-checking bench for prop_checker (4 channels, 2-bit counters, 3-bit window).
module tb_prop_checker;
  import prop_checker_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [3:0] a, b;
  logic [7:0] mode;
  logic [2:0] win;
  logic [3:0] pass_p, fail_p, fail_sticky;
  logic [7:0] fail_cnt;
  logic       first_vld;
  logic [1:0] first_ch;

  int vectors = 0;
  int errors  = 0;

  prop_checker #(.NUM_CH(4), .CNT_W(2), .WIN_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .mode(mode), .win(win),
    .pass_p(pass_p), .fail_p(fail_p), .fail_sticky(fail_sticky), .fail_cnt(fail_cnt),
    .first_vld(first_vld), .first_ch(first_ch)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int ch, input chk_mode_e m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic do_clr;
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; clr = 1'b0; a = '0; b = '0; mode = 8'hFF; win = 3'd3;
    tick(); tick();
    vectors++; if (pass_p !== 4'b0) begin $display("FAIL rst_pass got %b exp 0000", pass_p); errors++; end
    vectors++; if (fail_p !== 4'b0) begin $display("FAIL rst_fail got %b exp 0000", fail_p); errors++; end
    vectors++; if (fail_cnt !== 8'h0) begin $display("FAIL rst_cnt got %h exp 00", fail_cnt); errors++; end
    vectors++; if ({first_vld, first_ch, fail_sticky} !== 7'b0) begin
      $display("FAIL rst_first got vld=%b ch=%0d sticky=%b exp 0", first_vld, first_ch, fail_sticky); errors++; end
    rst = 1'b0; tick();
    $display("test_reset done");
  endtask

  task automatic test_equal;
    set_mode(0, CHK_EQUAL); tick();
    vectors++; if (pass_p !== 4'b0) begin $display("FAIL eq_modechg pass got %b exp 0000", pass_p); errors++; end
    a = 4'b0001; b = 4'b0000; tick();
    vectors++; if (fail_p !== 4'b0001) begin $display("FAIL eq_10 fail got %b exp 0001", fail_p); errors++; end
    vectors++; if ({first_vld, first_ch} !== 3'b100) begin $display("FAIL eq_first got %b exp 100", {first_vld, first_ch}); errors++; end
    a = 4'b0001; b = 4'b0001; tick();
    vectors++; if (pass_p !== 4'b0001 || fail_p !== 4'b0) begin $display("FAIL eq_11 pass/fail got %b/%b exp 0001/0000", pass_p, fail_p); errors++; end
    a = 4'b0000; b = 4'b0001; tick();
    vectors++; if (fail_p !== 4'b0001) begin $display("FAIL eq_01 fail got %b exp 0001", fail_p); errors++; end
    vectors++; if (fail_cnt[1:0] !== 2'd2) begin $display("FAIL eq_cnt got %0d exp 2", fail_cnt[1:0]); errors++; end
    a = '0; b = '0; set_mode(0, CHK_OFF); tick(); do_clr();
    vectors++; if (fail_cnt !== 8'h0 || first_vld !== 1'b0) begin $display("FAIL eq_clr cnt=%h vld=%b exp 00/0", fail_cnt, first_vld); errors++; end
    $display("test_equal done");
  endtask

  task automatic test_mutex;
    set_mode(1, CHK_MUTEX); tick();
    a = 4'b0010; b = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (fail_p !== 4'b0010) begin $display("FAIL mx_viol%0d fail got %b exp 0010", i, fail_p); errors++; end
    end
    a = 4'b0000; tick();
    vectors++; if (pass_p !== 4'b0010 || fail_p !== 4'b0) begin $display("FAIL mx_pass pass/fail got %b/%b exp 0010/0000", pass_p, fail_p); errors++; end
    vectors++; if (fail_cnt[3:2] !== 2'd3) begin $display("FAIL mx_cnt got %0d exp 3", fail_cnt[3:2]); errors++; end
    vectors++; if ({first_vld, first_ch} !== 3'b101) begin $display("FAIL mx_first got %b exp 101", {first_vld, first_ch}); errors++; end
    $display("test_mutex done");
  endtask

  task automatic test_saturate_clr;
    do_clr();
    a = 4'b0010; b = 4'b0010;
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (fail_cnt[3:2] !== 2'd3 || fail_sticky !== 4'b0010) begin
      $display("FAIL sat_cnt cnt=%0d sticky=%b exp 3/0010", fail_cnt[3:2], fail_sticky); errors++; end
    clr = 1'b1; tick(); clr = 1'b0;
    vectors++; if (fail_p !== 4'b0010) begin $display("FAIL clr_pulse fail got %b exp 0010", fail_p); errors++; end
    vectors++; if (fail_cnt !== 8'h0 || fail_sticky !== 4'b0 || first_vld !== 1'b0) begin
      $display("FAIL clr_wins cnt=%h sticky=%b vld=%b exp 00/0000/0", fail_cnt, fail_sticky, first_vld); errors++; end
    a = '0; b = '0; set_mode(1, CHK_OFF); tick(); do_clr();
    $display("test_saturate_clr done");
  endtask

  task automatic test_imply;
    logic [3:0] seen;
    win = 3'd3; set_mode(2, CHK_IMPLY); tick();
    // b two cycles after a -> one pass
    a = 4'b0100; tick(); a = '0; tick();
    vectors++; if ((pass_p | fail_p) !== 4'b0) begin $display("FAIL im_wait got %b exp 0000", pass_p | fail_p); errors++; end
    b = 4'b0100; tick(); b = '0;
    vectors++; if (pass_p !== 4'b0100 || fail_p !== 4'b0) begin $display("FAIL im_pass pass/fail got %b/%b exp 0100/0000", pass_p, fail_p); errors++; end
    tick();
    vectors++; if (pass_p !== 4'b0) begin $display("FAIL im_single got %b exp 0000", pass_p); errors++; end
    // no b -> fail exactly 3 cycles after a
    a = 4'b0100; tick(); a = '0; seen = '0;
    tick(); seen |= fail_p; tick(); seen |= fail_p;
    vectors++; if (seen !== 4'b0) begin $display("FAIL im_early got %b exp 0000", seen); errors++; end
    tick();
    vectors++; if (fail_p !== 4'b0100) begin $display("FAIL im_timeout got %b exp 0100", fail_p); errors++; end
    // a held through the window and on the fail cycle: no re-arm
    a = 4'b0100; tick(); tick(); tick(); tick();
    vectors++; if (fail_p !== 4'b0100) begin $display("FAIL im_heldfail got %b exp 0100", fail_p); errors++; end
    a = '0; seen = '0;
    for (int i = 0; i < 4; i++) begin tick(); seen |= fail_p | pass_p; end
    vectors++; if (seen !== 4'b0) begin $display("FAIL im_norearm got %b exp 0000", seen); errors++; end
    // same-cycle b does not satisfy
    a = 4'b0100; b = 4'b0100; tick();
    vectors++; if (pass_p !== 4'b0) begin $display("FAIL im_samecyc got %b exp 0000", pass_p); errors++; end
    a = '0; tick(); b = '0;
    vectors++; if (pass_p !== 4'b0100) begin $display("FAIL im_nextpass got %b exp 0100", pass_p); errors++; end
    // window shrunk mid-flight fails immediately
    a = 4'b0100; tick(); a = '0; tick(); win = 3'd1; tick();
    vectors++; if (fail_p !== 4'b0100) begin $display("FAIL im_winshrink got %b exp 0100", fail_p); errors++; end
    // win=0 behaves as 1
    win = 3'd0; a = 4'b0100; tick(); a = '0; tick();
    vectors++; if (fail_p !== 4'b0100) begin $display("FAIL im_win0 got %b exp 0100", fail_p); errors++; end
    // en low freezes the window
    win = 3'd3; a = 4'b0100; tick(); a = '0; en = 1'b0; seen = '0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= fail_p | pass_p; end
    vectors++; if (seen !== 4'b0) begin $display("FAIL im_frozen got %b exp 0000", seen); errors++; end
    en = 1'b1; b = 4'b0100; tick(); b = '0;
    vectors++; if (pass_p !== 4'b0100) begin $display("FAIL im_unfreeze got %b exp 0100", pass_p); errors++; end
    set_mode(2, CHK_OFF); tick(); do_clr();
    $display("test_imply done");
  endtask

  task automatic test_first_fail;
    set_mode(0, CHK_EQUAL); set_mode(1, CHK_MUTEX); set_mode(3, CHK_MUTEX); tick();
    a = 4'b1010; b = 4'b1010; tick();
    vectors++; if (fail_p !== 4'b1010) begin $display("FAIL ff_simul fail got %b exp 1010", fail_p); errors++; end
    vectors++; if ({first_vld, first_ch} !== 3'b101) begin $display("FAIL ff_lowest got %b exp 101", {first_vld, first_ch}); errors++; end
    a = 4'b0001; b = 4'b0000; tick();
    vectors++; if (fail_p !== 4'b0001 || {first_vld, first_ch} !== 3'b101) begin
      $display("FAIL ff_hold fail=%b first=%b exp 0001/101", fail_p, {first_vld, first_ch}); errors++; end
    a = '0; b = '0; mode = 8'hFF; tick(); do_clr();
    $display("test_first_fail done");
  endtask

  task automatic test_reset_mid;
    logic [3:0] seen;
    win = 3'd3; set_mode(2, CHK_IMPLY); set_mode(1, CHK_MUTEX); tick();
    a = 4'b0110; b = 4'b0010; tick();
    vectors++; if (fail_sticky !== 4'b0010) begin $display("FAIL rm_pre sticky got %b exp 0010", fail_sticky); errors++; end
    a = '0; b = '0; rst = 1'b1; tick(); rst = 1'b0;
    vectors++; if ({pass_p, fail_p, fail_sticky, fail_cnt, first_vld} !== 21'b0) begin
      $display("FAIL rm_clear got pass=%b fail=%b sticky=%b cnt=%h vld=%b exp 0", pass_p, fail_p, fail_sticky, fail_cnt, first_vld); errors++; end
    seen = '0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= fail_p; end
    vectors++; if (seen[2] !== 1'b0) begin $display("FAIL rm_nolate got %b exp 0", seen[2]); errors++; end
    $display("test_reset_mid done");
  endtask

  task automatic test_mode_change;
    a = 4'b0100; tick();
    set_mode(2, CHK_EQUAL); a = 4'b0100; b = '0; tick();
    vectors++; if ((pass_p[2] | fail_p[2]) !== 1'b0) begin $display("FAIL mc_abort got %b exp 0", pass_p[2] | fail_p[2]); errors++; end
    tick();
    vectors++; if (fail_p[2] !== 1'b1) begin $display("FAIL mc_eqfail got %b exp 1", fail_p[2]); errors++; end
    b = 4'b0100; tick();
    vectors++; if (pass_p[2] !== 1'b1 || fail_p[2] !== 1'b0) begin $display("FAIL mc_eqpass pass/fail got %b/%b exp 1/0", pass_p[2], fail_p[2]); errors++; end
    a = '0; b = '0; mode = 8'hFF; tick();
    $display("test_mode_change done");
  endtask

  initial begin
    test_reset();
    test_equal();
    test_mutex();
    test_saturate_clr();
    test_imply();
    test_first_fail();
    test_reset_mid();
    test_mode_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/prop_checker.md
Name: prop_checker

Overview:
- Parametrised hardware property checker. It watches NUM_CH independent (a, b) signal pairs and flags rule violations in silicon.
- Each channel applies one rule, selected at run time:
  - equality (a == b)
  - mutual exclusion (not (a && b))
  - bounded implication (a |-> ##[1:win] b)
- Per channel it reports pass/fail pulses, a sticky fail flag and a saturating fail counter. Globally it captures which channel failed first.
- It sits beside DUT logic as a synthesizable monitor, and its outputs feed debug/status registers.

Parameters:
- NUM_CH, 4, number of monitored channel pairs (1..32).
- CNT_W, 8, width of each per-channel fail counter.
- WIN_W, 3, width of the implication window field; window 1..2^WIN_W-1 cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global check enable; when low, no evaluation and no window progress.
- clr  in  1  synchronous clear of sticky flags, counters and first-fail capture.
- a  in  NUM_CH  antecedent/left operand per channel.
- b  in  NUM_CH  consequent/right operand per channel.
- mode  in  2*NUM_CH  per-channel rule: 0 EQUAL, 1 MUTEX, 2 IMPLY, 3 OFF.
- win  in  WIN_W  implication window, shared by all channels; 0 is treated as 1.
- pass_p  out  NUM_CH  one-cycle pass pulse.
- fail_p  out  NUM_CH  one-cycle fail pulse.
- fail_sticky  out  NUM_CH  set on fail, held until clr/rst.
- fail_cnt  out  CNT_W*NUM_CH  per-channel saturating fail count; channel i occupies bits [i*CNT_W +: CNT_W].
- first_vld  out  1  a first failure has been captured.
- first_ch  out  $clog2(NUM_CH) (min 1)  index of first failing channel.

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-high.
  - On rst, all outputs are 0, all lanes go to IDLE and window counters are 0.
- Latency: inputs are sampled at posedge N. The resulting pass_p/fail_p are valid after posedge N, i.e. one registered stage.
- EQUAL: each enabled cycle gives pass_p if a==b, else fail_p.
- MUTEX: each enabled cycle gives fail_p if a&&b, else pass_p.
- IMPLY, per-lane FSM:
  - IDLE:
    - a=1 -> WAIT, wcnt=1.
    - No pulse in IDLE.
  - WAIT:
    - b=1 -> pass_p, go to IDLE.
    - Else if wcnt==max(win,1) -> fail_p, go to IDLE.
    - Else wcnt++.
  - b is checked only from the cycle after a (no same-cycle satisfaction).
  - A new a while in WAIT is ignored (no overlapping windows).
  - A pass or fail in WAIT does not re-arm from an a seen in that same cycle.
- OFF: no pulses, and the lane is forced to IDLE.
- Mode change: if a lane's mode differs from its registered previous mode, the lane aborts to IDLE with no pulse that cycle.
- Enable: en=0 freezes the FSM and wcnt and suppresses pulses. Sticky flags and counters hold.
- win change mid-window: the new value takes effect immediately. If wcnt already ≥ the new bound and b=0, the lane fails that cycle.
- Fail side effects: each fail_p sets fail_sticky[i] and increments fail_cnt[i], saturating at 2^CNT_W-1 with no wrap.
- First-fail capture:
  - While first_vld=0, the first cycle with any fail latches first_ch and sets first_vld.
  - Simultaneous fails capture the lowest index.
  - Later fails do not overwrite the capture.
- clr:
  - Zeroes fail_sticky, fail_cnt and first_vld/first_ch.
  - Does not affect FSM state or pulses.
  - A fail in the same cycle as clr is not recorded in sticky/count/first-fail (clr wins); its fail_p still pulses.
- Priority: rst > clr > event updates.

Decomposition:
- Package prop_checker_pkg holds:
  - enum chk_mode_e {CHK_EQUAL, CHK_MUTEX, CHK_IMPLY, CHK_OFF}
  - enum lane_state_e {LS_IDLE, LS_WAIT}
- Sub-module prop_chk_lane: one channel's rule, FSM, window counter, pulses, sticky flag and saturating counter. Instantiated NUM_CH times by generate.
- Top level holds first-fail priority capture and port packing.

Test Plan:
- EQUAL, ch0, a/b = 10, 11, 01 on successive cycles -> fail_p[0], pass_p[0], fail_p[0] one cycle later each; fail_cnt[0]=2; first_ch=0, first_vld=1.
- MUTEX, ch1, a=b=1 for 3 cycles then a=0 -> 3 fail_p then pass_p; fail_cnt[1]=3; pass_p[1] on the a=0 cycle.
- IMPLY with win=3, ch2:
  - a pulse, b at the 2nd cycle after -> single pass_p.
  - a pulse, no b -> fail_p exactly 3 cycles after a.
  - a pulses during WAIT -> no extra window.
- CNT_W=2, MUTEX violation held 6 cycles -> fail_cnt saturates at 3. clr with a concurrent fail -> sticky/count stay 0 and fail_p still pulses.
- Simultaneous fails on ch3 and ch1 with first_vld=0 -> first_ch=1. A later ch0 fail does not change it.
- Reset mid-window, and mode change IMPLY->EQUAL mid-window:
  - rst -> all outputs 0 the next cycle and no late fail.
  - Mode change -> no pulse on the change cycle, EQUAL checking from the next cycle.
